// File: rtl/core_debug_manager_pkg.sv
// Shared register map, halt-cause encodings and helpers for the core debug manager.
package core_debug_pkg;

    // Register-space offsets (word aligned, address[11:0])
    localparam logic [11:0] REG_CONTROL    = 12'h000;
    localparam logic [11:0] REG_STATUS     = 12'h004;
    localparam logic [11:0] REG_STEP_COUNT = 12'h008;

    // Breakpoint channels start at slot 1 (0x010) and occupy 0x10 bytes each
    localparam int unsigned BP_STRIDE_SHIFT = 4;
    localparam logic [7:0]  BP_FIRST_SLOT   = 8'h01;

    // Word select within a channel slot
    localparam logic [1:0] BP_REG_ADDRESS = 2'd0;
    localparam logic [1:0] BP_REG_MASK    = 2'd1;
    localparam logic [1:0] BP_REG_CONFIG  = 2'd2;

    // Channel config bits
    localparam int unsigned BP_CFG_ENABLE = 0;
    localparam int unsigned BP_CFG_TYPE   = 1;

    // Control register bits
    localparam int unsigned CTRL_RUN  = 0;
    localparam int unsigned CTRL_IRQ  = 1;
    localparam int unsigned CTRL_STEP = 2;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_BREAKPOINT = 2'd1,
        CAUSE_STEP       = 2'd2,
        CAUSE_MANUAL     = 2'd3
    } haltCause_t;

    typedef enum logic {
        BP_INSTRUCTION = 1'b0,
        BP_DATA        = 1'b1
    } bpType_t;

    // Merge newValue into oldValue on the enabled byte lanes only
    function automatic logic [31:0] applyBytes(input logic [31:0] oldValue,
                                               input logic [31:0] newValue,
                                               input logic [3:0]  lanes);
        logic [31:0] result;
        result = oldValue;
        for (int unsigned i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                result[8*i +: 8] = newValue[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/core_debug_manager_breakpoint_channel.sv
// One masked breakpoint channel: address/mask/config registers and a registered hit flag.
module breakpoint_channel
    import core_debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        writeEnable,
    input  logic [1:0]  regSelect,
    input  logic [3:0]  byteSelect,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    input  logic [31:0] coreInstructionAddress,
    input  logic [31:0] coreDataAddress,
    input  logic        coreDataValid,
    input  logic        run,
    output logic        hit
);

    logic [31:0] bpAddress;
    logic [31:0] bpMask;
    logic        bpEnable;
    bpType_t     bpType;
    logic [31:0] compareAddress;
    logic        match;

    // Channel register writes, masked per byte lane
    always_ff @(posedge clk) begin
        if (rst) begin
            bpAddress <= '1;
            bpMask    <= '0;
            bpEnable  <= 1'b0;
            bpType    <= BP_INSTRUCTION;
        end else if (writeEnable) begin
            case (regSelect)
                BP_REG_ADDRESS: bpAddress <= applyBytes(bpAddress, writeData, byteSelect);
                BP_REG_MASK:    bpMask    <= applyBytes(bpMask, writeData, byteSelect);
                BP_REG_CONFIG: begin
                    if (byteSelect[0]) begin
                        bpEnable <= writeData[BP_CFG_ENABLE];
                        bpType   <= bpType_t'(writeData[BP_CFG_TYPE]);
                    end
                end
                default: ;
            endcase
        end
    end

    // Masked compare against the fetch or data address
    always_comb begin
        compareAddress = (bpType == BP_DATA) ? coreDataAddress : coreInstructionAddress;
        match = bpEnable
             && (((compareAddress ^ bpAddress) & ~bpMask) == '0)
             && ((bpType == BP_INSTRUCTION) || coreDataValid);
    end

    // Hit flag registered one cycle after the address; suppressed while the core is stopped
    always_ff @(posedge clk) begin
        if (rst) begin
            hit <= 1'b0;
        end else begin
            hit <= run && match;
        end
    end

    // Register readback
    always_comb begin
        case (regSelect)
            BP_REG_ADDRESS: readData = bpAddress;
            BP_REG_MASK:    readData = bpMask;
            BP_REG_CONFIG:  readData = {30'd0, bpType, bpEnable};
            default:        readData = '1;
        endcase
    end

endmodule

// File: rtl/core_debug_manager.sv
// Core management block: JTAG/Wishbone arbitration, run control, memory window,
// breakpoint channels, step counter and sticky halt cause.
module core_debug_manager
    import core_debug_pkg::*;
#(
    parameter int unsigned BREAKPOINT_COUNT   = 4,
    parameter int unsigned CORE_ADDRESS_WIDTH = 16,
    parameter int unsigned STEP_WIDTH         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          management_run,
    output logic                          management_interruptEnable,
    output logic                          management_writeEnable,
    output logic [3:0]                    management_byteSelect,
    output logic [CORE_ADDRESS_WIDTH-1:0] management_address,
    output logic [31:0]                   management_writeData,
    input  logic [31:0]                   management_readData,
    input  logic [31:0]                   coreInstructionAddress,
    input  logic [31:0]                   coreDataAddress,
    input  logic                          coreDataValid,
    input  logic                          coreRetire,
    output logic                          halted,
    input  logic                          jtag_management_enable,
    input  logic                          jtag_management_writeEnable,
    input  logic [3:0]                    jtag_management_byteSelect,
    input  logic [19:0]                   jtag_management_address,
    input  logic [31:0]                   jtag_management_writeData,
    output logic [31:0]                   jtag_management_readData,
    input  logic                          wb_management_enable,
    input  logic                          wb_management_writeEnable,
    input  logic [3:0]                    wb_management_byteSelect,
    input  logic [19:0]                   wb_management_address,
    input  logic [31:0]                   wb_management_writeData,
    output logic [31:0]                   wb_management_readData,
    output logic                          wb_management_busy
);

    localparam logic [7:0] BP_COUNT8 = 8'(BREAKPOINT_COUNT);

    logic        busEnable;
    logic        busWriteEnable;
    logic [3:0]  busByteSelect;
    logic [19:0] busAddress;
    logic [31:0] busWriteData;
    logic [31:0] busReadData;
    logic [31:0] regRead;

    logic        regSpace;
    logic        windowSpace;
    logic        windowAccess;
    logic [11:0] regOffset;
    logic [7:0]  chanSlot;
    logic [7:0]  chanIndex;
    logic        chanValid;
    logic        regWrite;
    logic        controlWrite;
    logic        stepWrite;

    logic [2:0]            ctrl;
    logic [2:0]            ctrlNext;
    haltCause_t            cause;
    haltCause_t            causeNext;
    logic [3:0]            haltIndex;
    logic [3:0]            haltIndexNext;
    logic [STEP_WIDTH-1:0] stepCount;
    logic [STEP_WIDTH-1:0] stepNext;
    logic                  run;

    logic [BREAKPOINT_COUNT-1:0] chWrite;
    logic [BREAKPOINT_COUNT-1:0] chHit;
    logic [31:0]                 chReadData [BREAKPOINT_COUNT];
    logic [3:0]                  bpIndex;
    logic                        bpEvent;
    logic                        stepEvent;

    assign run = ctrl[CTRL_RUN];

    // JTAG has strict priority; Wishbone is stalled while both request
    always_comb begin
        busEnable      = jtag_management_enable || wb_management_enable;
        busWriteEnable = jtag_management_enable ? jtag_management_writeEnable : wb_management_writeEnable;
        busByteSelect  = jtag_management_enable ? jtag_management_byteSelect  : wb_management_byteSelect;
        busAddress     = jtag_management_enable ? jtag_management_address     : wb_management_address;
        busWriteData   = jtag_management_enable ? jtag_management_writeData   : wb_management_writeData;
    end

    assign wb_management_busy       = jtag_management_enable && wb_management_enable;
    assign jtag_management_readData = busReadData;
    assign wb_management_readData   = busReadData;

    // Address decode
    assign regSpace     = (busAddress[19:12] == 8'h00);
    assign windowSpace  = (busAddress[19:16] == 4'h1);
    assign regOffset    = {busAddress[11:2], 2'b00};
    assign chanSlot     = busAddress[11:BP_STRIDE_SHIFT];
    assign chanIndex    = chanSlot - BP_FIRST_SLOT;
    assign chanValid    = (chanSlot >= BP_FIRST_SLOT) && (chanIndex < BP_COUNT8)
                       && (busAddress[3:2] != 2'b11);
    assign regWrite     = busEnable && busWriteEnable && regSpace;
    assign controlWrite = regWrite && (regOffset == REG_CONTROL) && busByteSelect[0];
    assign stepWrite    = regWrite && (regOffset == REG_STEP_COUNT) && (busByteSelect != 4'd0);

    // Core memory window, only reachable while the core is stopped
    assign windowAccess           = busEnable && windowSpace && !run && !rst;
    assign management_writeEnable = windowAccess && busWriteEnable;
    assign management_byteSelect  = windowAccess ? busByteSelect : '0;
    assign management_address     = windowAccess ? CORE_ADDRESS_WIDTH'(busAddress[15:0]) : '0;
    assign management_writeData   = windowAccess ? busWriteData : '0;

    assign management_run             = ctrl[CTRL_RUN];
    assign management_interruptEnable = ctrl[CTRL_IRQ];

    for (genvar n = 0; n < BREAKPOINT_COUNT; n++) begin : gen_channel
        assign chWrite[n] = regWrite && chanValid && (chanIndex == 8'(n));

        breakpoint_channel u_channel (
            .clk                    (clk),
            .rst                    (rst),
            .writeEnable            (chWrite[n]),
            .regSelect              (busAddress[3:2]),
            .byteSelect             (busByteSelect),
            .writeData              (busWriteData),
            .readData               (chReadData[n]),
            .coreInstructionAddress (coreInstructionAddress),
            .coreDataAddress        (coreDataAddress),
            .coreDataValid          (coreDataValid),
            .run                    (run),
            .hit                    (chHit[n])
        );
    end

    // Zero-latency read mux; anything unmapped reads all ones
    always_comb begin
        regRead = '1;
        case (regOffset)
            REG_CONTROL:    regRead = 32'(ctrl);
            REG_STATUS:     regRead = {20'd0, haltIndex, 6'd0, cause};
            REG_STEP_COUNT: regRead = 32'(stepCount);
            default: begin
                for (int unsigned i = 0; i < BREAKPOINT_COUNT; i++) begin
                    if (chanValid && (chanIndex == 8'(i))) begin
                        regRead = chReadData[i];
                    end
                end
            end
        endcase
        if (regSpace) begin
            busReadData = regRead;
        end else if (windowSpace && !run) begin
            busReadData = management_readData;
        end else begin
            busReadData = '1;
        end
    end

    // Lowest-numbered hitting channel wins
    always_comb begin
        bpIndex = '0;
        for (int unsigned i = BREAKPOINT_COUNT; i > 0; i--) begin
            if (chHit[i-1]) begin
                bpIndex = 4'(i - 1);
            end
        end
    end

    assign bpEvent   = run && (chHit != '0);
    assign stepEvent = run && ctrl[CTRL_STEP] && coreRetire && !stepWrite
                    && (stepCount <= STEP_WIDTH'(1));

    // Next-state for control, status and step counter; a control write overrides any halt event
    always_comb begin
        ctrlNext      = ctrl;
        causeNext     = cause;
        haltIndexNext = haltIndex;
        stepNext      = stepCount;

        if (stepWrite) begin
            stepNext = STEP_WIDTH'(applyBytes(32'(stepCount), busWriteData, busByteSelect));
        end else if (run && ctrl[CTRL_STEP] && coreRetire) begin
            // A count of 0 behaves like 1 and never wraps
            stepNext = (stepCount > STEP_WIDTH'(1)) ? stepCount - STEP_WIDTH'(1) : '0;
        end

        if (controlWrite) begin
            ctrlNext = busWriteData[2:0];
            if (busWriteData[CTRL_RUN]) begin
                causeNext     = CAUSE_NONE;
                haltIndexNext = '0;
            end else if (run) begin
                causeNext     = CAUSE_MANUAL;
                haltIndexNext = '0;
            end
        end else if (bpEvent) begin
            ctrlNext[CTRL_RUN] = 1'b0;
            causeNext          = CAUSE_BREAKPOINT;
            haltIndexNext      = bpIndex;
        end else if (stepEvent) begin
            ctrlNext[CTRL_RUN] = 1'b0;
            causeNext          = CAUSE_STEP;
            haltIndexNext      = '0;
        end
    end

    // Control/status state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl      <= '0;
            cause     <= CAUSE_NONE;
            haltIndex <= '0;
            stepCount <= '0;
            halted    <= 1'b0;
        end else begin
            ctrl      <= ctrlNext;
            cause     <= causeNext;
            haltIndex <= haltIndexNext;
            stepCount <= stepNext;
            halted    <= !ctrlNext[CTRL_RUN] && (causeNext != CAUSE_NONE);
        end
    end

endmodule

// File: tb/tb_core_debug_manager.sv
// Directed bench for core_debug_manager with a queue of expected values.
module tb_core_debug_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        management_run;
    logic        management_interruptEnable;
    logic        management_writeEnable;
    logic [3:0]  management_byteSelect;
    logic [15:0] management_address;
    logic [31:0] management_writeData;
    logic [31:0] management_readData;
    logic [31:0] coreInstructionAddress;
    logic [31:0] coreDataAddress;
    logic        coreDataValid;
    logic        coreRetire;
    logic        halted;
    logic        jtag_management_enable;
    logic        jtag_management_writeEnable;
    logic [3:0]  jtag_management_byteSelect;
    logic [19:0] jtag_management_address;
    logic [31:0] jtag_management_writeData;
    logic [31:0] jtag_management_readData;
    logic        wb_management_enable;
    logic        wb_management_writeEnable;
    logic [3:0]  wb_management_byteSelect;
    logic [19:0] wb_management_address;
    logic [31:0] wb_management_writeData;
    logic [31:0] wb_management_readData;
    logic        wb_management_busy;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    expect_t scoreboard [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_debug_manager #(
        .BREAKPOINT_COUNT   (4),
        .CORE_ADDRESS_WIDTH (16),
        .STEP_WIDTH         (16)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .management_run              (management_run),
        .management_interruptEnable  (management_interruptEnable),
        .management_writeEnable      (management_writeEnable),
        .management_byteSelect       (management_byteSelect),
        .management_address          (management_address),
        .management_writeData        (management_writeData),
        .management_readData         (management_readData),
        .coreInstructionAddress      (coreInstructionAddress),
        .coreDataAddress             (coreDataAddress),
        .coreDataValid               (coreDataValid),
        .coreRetire                  (coreRetire),
        .halted                      (halted),
        .jtag_management_enable      (jtag_management_enable),
        .jtag_management_writeEnable (jtag_management_writeEnable),
        .jtag_management_byteSelect  (jtag_management_byteSelect),
        .jtag_management_address     (jtag_management_address),
        .jtag_management_writeData   (jtag_management_writeData),
        .jtag_management_readData    (jtag_management_readData),
        .wb_management_enable        (wb_management_enable),
        .wb_management_writeEnable   (wb_management_writeEnable),
        .wb_management_byteSelect    (wb_management_byteSelect),
        .wb_management_address       (wb_management_address),
        .wb_management_writeData     (wb_management_writeData),
        .wb_management_readData      (wb_management_readData),
        .wb_management_busy          (wb_management_busy)
    );

    task automatic pushExpect(input string tag, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        scoreboard.push_back(e);
    endtask

    task automatic popCheck(input logic [31:0] observed);
        expect_t e;
        checks++;
        if (scoreboard.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed %h expected none", observed);
        end else begin
            e = scoreboard.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic jtagWrite(input logic [19:0] addr, input logic [31:0] data, input logic [3:0] lanes);
        jtag_management_enable      = 1'b1;
        jtag_management_writeEnable = 1'b1;
        jtag_management_byteSelect  = lanes;
        jtag_management_address     = addr;
        jtag_management_writeData   = data;
        @(posedge clk);
        #1;
        jtag_management_enable      = 1'b0;
        jtag_management_writeEnable = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [19:0] addr, input logic [31:0] expected);
        logic [31:0] data;
        pushExpect(tag, expected);
        jtag_management_enable      = 1'b1;
        jtag_management_writeEnable = 1'b0;
        jtag_management_address     = addr;
        #1;
        data = jtag_management_readData;
        jtag_management_enable = 1'b0;
        popCheck(data);
    endtask

    task automatic sigCheck(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        pushExpect(tag, expected);
        popCheck(observed);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst                         = 1'b1;
        management_readData         = 32'h0;
        coreInstructionAddress      = 32'h0;
        coreDataAddress             = 32'h0;
        coreDataValid               = 1'b0;
        coreRetire                  = 1'b0;
        jtag_management_enable      = 1'b0;
        jtag_management_writeEnable = 1'b0;
        jtag_management_byteSelect  = 4'hF;
        jtag_management_address     = 20'h0;
        jtag_management_writeData   = 32'h0;
        wb_management_enable        = 1'b0;
        wb_management_writeEnable   = 1'b0;
        wb_management_byteSelect    = 4'hF;
        wb_management_address       = 20'h0;
        wb_management_writeData     = 32'h0;
        tick(2);
        rst = 1'b0;
        tick(1);

        // Reset state
        readCheck("reset_control", 20'h00000, 32'h0);
        readCheck("reset_status", 20'h00004, 32'h0);
        readCheck("reset_step", 20'h00008, 32'h0);
        readCheck("reset_ch0_addr", 20'h00010, 32'hFFFF_FFFF);
        readCheck("reset_ch0_mask", 20'h00014, 32'h0);
        sigCheck("reset_halted", 32'(halted), 32'h0);
        sigCheck("reset_mgmt_we", 32'(management_writeEnable), 32'h0);
        wb_management_enable  = 1'b1;
        wb_management_address = 20'h00FF0;
        #1;
        sigCheck("wb_unmapped_read", wb_management_readData, 32'hFFFF_FFFF);
        wb_management_enable = 1'b0;

        // Channel 1 instruction breakpoint, masked low nibble
        jtagWrite(20'h00020, 32'h0000_0100, 4'hF);
        jtagWrite(20'h00024, 32'h0000_000F, 4'hF);
        jtagWrite(20'h00028, 32'h0000_0001, 4'hF);
        jtagWrite(20'h00000, 32'h0000_0001, 4'hF);
        readCheck("bp_run_set", 20'h00000, 32'h1);
        coreInstructionAddress = 32'h0000_010C;
        tick(1);
        readCheck("bp_run_after_1", 20'h00000, 32'h1);
        tick(1);
        readCheck("bp_run_after_2", 20'h00000, 32'h0);
        readCheck("bp_status", 20'h00004, 32'h0000_0101);
        sigCheck("bp_halted", 32'(halted), 32'h1);
        coreInstructionAddress = 32'h0;

        // Channels 0 and 2 data breakpoints on the same address
        jtagWrite(20'h00028, 32'h0, 4'hF);
        jtagWrite(20'h00010, 32'h0000_2000, 4'hF);
        jtagWrite(20'h00014, 32'h0, 4'hF);
        jtagWrite(20'h00018, 32'h3, 4'hF);
        jtagWrite(20'h00030, 32'h0000_2000, 4'hF);
        jtagWrite(20'h00034, 32'h0000_00FF, 4'hF);
        jtagWrite(20'h00038, 32'h3, 4'hF);
        coreDataAddress = 32'h0000_2000;
        jtagWrite(20'h00000, 32'h1, 4'hF);
        readCheck("data_status_cleared", 20'h00004, 32'h0);
        sigCheck("data_halted_cleared", 32'(halted), 32'h0);
        tick(4);
        readCheck("data_invalid_no_halt", 20'h00000, 32'h1);
        coreDataValid = 1'b1;
        tick(1);
        coreDataValid = 1'b0;
        tick(1);
        readCheck("data_run_dropped", 20'h00000, 32'h0);
        readCheck("data_lowest_index", 20'h00004, 32'h0000_0001);
        jtagWrite(20'h00018, 32'h0, 4'hF);
        jtagWrite(20'h00038, 32'h0, 4'hF);
        coreDataAddress = 32'h0;

        // Step counter
        jtagWrite(20'h00008, 32'h3, 4'hF);
        readCheck("step_loaded", 20'h00008, 32'h3);
        jtagWrite(20'h00000, 32'h5, 4'hF);
        coreRetire = 1'b1;
        tick(2);
        readCheck("step_count_1", 20'h00008, 32'h1);
        readCheck("step_still_running", 20'h00000, 32'h5);
        tick(1);
        coreRetire = 1'b0;
        readCheck("step_control", 20'h00000, 32'h4);
        readCheck("step_status", 20'h00004, 32'h2);
        readCheck("step_count_0", 20'h00008, 32'h0);
        sigCheck("step_halted", 32'(halted), 32'h1);
        jtagWrite(20'h00000, 32'h1, 4'hF);
        readCheck("run_clears_status", 20'h00004, 32'h0);
        sigCheck("run_clears_halted", 32'(halted), 32'h0);
        jtagWrite(20'h00000, 32'h0, 4'hF);
        readCheck("manual_status", 20'h00004, 32'h3);
        sigCheck("manual_halted", 32'(halted), 32'h1);

        // Arbitration: JTAG first, Wishbone completes after JTAG drops
        jtag_management_enable      = 1'b1;
        jtag_management_writeEnable = 1'b1;
        jtag_management_byteSelect  = 4'hF;
        jtag_management_address     = 20'h00008;
        jtag_management_writeData   = 32'h55;
        wb_management_enable        = 1'b1;
        wb_management_writeEnable   = 1'b1;
        wb_management_byteSelect    = 4'hF;
        wb_management_address       = 20'h00008;
        wb_management_writeData     = 32'hAA;
        #1;
        sigCheck("arb_busy", 32'(wb_management_busy), 32'h1);
        sigCheck("arb_shared_read", wb_management_readData, 32'h0);
        tick(1);
        jtag_management_enable      = 1'b0;
        jtag_management_writeEnable = 1'b0;
        #1;
        sigCheck("arb_busy_released", 32'(wb_management_busy), 32'h0);
        sigCheck("arb_jtag_landed", wb_management_readData, 32'h55);
        tick(1);
        wb_management_enable      = 1'b0;
        wb_management_writeEnable = 1'b0;
        readCheck("arb_wb_landed", 20'h00008, 32'hAA);

        // Core window gating by run
        jtagWrite(20'h00000, 32'h1, 4'hF);
        jtag_management_enable      = 1'b1;
        jtag_management_writeEnable = 1'b1;
        jtag_management_address     = 20'h10004;
        jtag_management_writeData   = 32'h1234_5678;
        jtag_management_byteSelect  = 4'hF;
        #1;
        sigCheck("win_we_running", 32'(management_writeEnable), 32'h0);
        jtag_management_enable      = 1'b0;
        jtag_management_writeEnable = 1'b0;
        readCheck("win_read_running", 20'h10004, 32'hFFFF_FFFF);
        jtagWrite(20'h00000, 32'h0, 4'hF);
        jtag_management_enable      = 1'b1;
        jtag_management_writeEnable = 1'b1;
        jtag_management_address     = 20'h10004;
        jtag_management_writeData   = 32'h1234_5678;
        jtag_management_byteSelect  = 4'h3;
        #1;
        sigCheck("win_we_halted", 32'(management_writeEnable), 32'h1);
        sigCheck("win_address", 32'(management_address), 32'h0000_0004);
        sigCheck("win_wdata", management_writeData, 32'h1234_5678);
        sigCheck("win_lanes", 32'(management_byteSelect), 32'h3);
        jtag_management_enable      = 1'b0;
        jtag_management_writeEnable = 1'b0;
        management_readData = 32'hCAFE_F00D;
        readCheck("win_read_halted", 20'h10008, 32'hCAFE_F00D);

        // Byte-lane masked register write
        jtagWrite(20'h00010, 32'hAABB_CCDD, 4'b0001);
        readCheck("byte_lane_write", 20'h00010, 32'h0000_20DD);

        // Reset with a hit flag pending
        jtagWrite(20'h00028, 32'h1, 4'hF);
        jtagWrite(20'h00000, 32'h1, 4'hF);
        coreInstructionAddress = 32'h0000_0100;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        readCheck("rst_control", 20'h00000, 32'h0);
        readCheck("rst_status", 20'h00004, 32'h0);
        readCheck("rst_ch1_addr", 20'h00020, 32'hFFFF_FFFF);
        readCheck("rst_ch1_config", 20'h00028, 32'h0);
        sigCheck("rst_halted", 32'(halted), 32'h0);
        tick(1);
        readCheck("rst_no_late_halt", 20'h00004, 32'h0);
        sigCheck("rst_halted_later", 32'(halted), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
